// File: rtl/rca_config_unit_pkg.sv
// Shared parameters and types for the RCA configuration unit.
// rca_config holds the table geometry; taiga_types holds the packet, table and FSM types.
package rca_config;
  localparam int NUM_RCAS        = 3;
  localparam int NUM_READ_PORTS  = 5;
  localparam int NUM_WRITE_PORTS = 2;
  localparam int MAX_INFLIGHT    = 4;

  localparam int RCA_SEL_W = $clog2(NUM_RCAS);
  localparam int CNT_W     = $clog2(MAX_INFLIGHT + 1);
  localparam int RD_IDX_W  = $clog2(NUM_READ_PORTS);
  localparam int WR_IDX_W  = $clog2(NUM_WRITE_PORTS);
endpackage

package taiga_types;
  import rca_config::*;

  localparam int XLEN       = 32;
  localparam int ID_W       = 4;
  localparam int REG_ADDR_W = 5;
  // Wide enough for the larger of the two tables.
  localparam int PORT_SEL_W = 3;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic                   rca_config_instr;
    logic [RCA_SEL_W-1:0]   rca_sel;
    logic [PORT_SEL_W-1:0]  w_port_sel;
    logic                   w_src_dest_port;
    logic [REG_ADDR_W-1:0]  w_reg_addr;
  } rca_inputs_t;

  typedef struct packed {
    logic [RCA_SEL_W-1:0]   rca_sel;
    logic [PORT_SEL_W-1:0]  w_port_sel;
    logic                   w_src_dest_port;
    logic [REG_ADDR_W-1:0]  w_reg_addr;
  } cfg_req_t;

  typedef struct packed {
    logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]  src;
    logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] dest;
  } rca_config_t;

  typedef enum logic [1:0] {
    RCA_CFG_IDLE    = 2'd0,
    RCA_CFG_DRAIN   = 2'd1,
    RCA_CFG_WRITE   = 2'd2,
    RCA_CFG_RESPOND = 2'd3
  } rca_cfg_state_t;
endpackage

// File: rtl/rca_config_unit_if.sv
// Issue-side request and writeback-side completion bundle for rca_config_unit.
// Handshakes: a request transfers on a clock edge where issue_valid && issue_ready;
// a completion transfers on an edge where wb_done && wb_ack, and wb_id/wb_data hold until then.
interface rca_config_unit_if;
  import taiga_types::*;

  logic             issue_valid;
  logic             issue_ready;
  id_t              issue_id;
  rca_inputs_t      rca_inputs;
  logic             wb_done;
  id_t              wb_id;
  logic [XLEN-1:0]  wb_data;
  logic             wb_ack;

  modport slave (
    input  issue_valid, issue_id, rca_inputs, wb_ack,
    output issue_ready, wb_done, wb_id, wb_data
  );

  modport master (
    output issue_valid, issue_id, rca_inputs, wb_ack,
    input  issue_ready, wb_done, wb_id, wb_data
  );
endinterface

// File: rtl/rca_inflight_counter.sv
// Saturating up/down count of in-flight uses for one RCA, with a zero flag.
module rca_inflight_counter
  import rca_config::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic zero
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != MAX_CNT)) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign zero = (count_q == '0);

`ifndef SYNTHESIS
  // Upstream must never issue a use to an RCA that already has MAX_INFLIGHT outstanding.
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst)
    !(inc && !dec && (count_q == MAX_CNT)));
`endif

endmodule

// File: rtl/rca_config_unit.sv
// Holds per-RCA source/destination register tables and applies config instructions once the RCA drains.
// Optional macro RCA_CONFIG_READBACK_EN: wb_data returns the overwritten table entry.
module rca_config_unit
  import rca_config::*;
  import taiga_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  rca_config_unit_if.slave      cfg_if,
  input  logic                  use_issued,
  input  logic [RCA_SEL_W-1:0]  use_issued_sel,
  input  logic                  use_complete,
  input  logic [RCA_SEL_W-1:0]  use_complete_sel,
  input  logic                  flush,
  input  logic [RCA_SEL_W-1:0]  lookup_sel,
  output rca_config_t           lookup_config,
  output logic [NUM_RCAS-1:0]   rca_busy,
  output rca_cfg_state_t        state_dbg
);

  rca_cfg_state_t       state_q, state_d;
  cfg_req_t             req_q, req_d;
  id_t                  id_q, id_d;
  logic [NUM_RCAS-1:0]  busy_q, busy_d;
  logic [NUM_RCAS-1:0]  zero_vec;
  rca_config_t          tables_q [NUM_RCAS];
  rca_config_t          tables_d [NUM_RCAS];

  logic sel_ok, src_ok, dest_ok, drained, accept;

  for (genvar i = 0; i < NUM_RCAS; i++) begin : g_cnt
    rca_inflight_counter u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (use_issued && (int'(use_issued_sel) == i)),
      .dec  (use_complete && (int'(use_complete_sel) == i)),
      .zero (zero_vec[i])
    );
  end

  assign accept  = cfg_if.issue_valid && cfg_if.rca_inputs.rca_config_instr;
  assign sel_ok  = int'(req_q.rca_sel) < NUM_RCAS;
  assign src_ok  = !req_q.w_src_dest_port && (int'(req_q.w_port_sel) < NUM_READ_PORTS);
  assign dest_ok = req_q.w_src_dest_port && (int'(req_q.w_port_sel) < NUM_WRITE_PORTS);
  // An unknown RCA select has nothing in flight; it simply completes with no write.
  assign drained = !sel_ok || zero_vec[req_q.rca_sel];

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    id_d     = id_q;
    busy_d   = busy_q;
    tables_d = tables_q;
    case (state_q)
      RCA_CFG_IDLE: begin
        if (accept) begin
          req_d.rca_sel         = cfg_if.rca_inputs.rca_sel;
          req_d.w_port_sel      = cfg_if.rca_inputs.w_port_sel;
          req_d.w_src_dest_port = cfg_if.rca_inputs.w_src_dest_port;
          req_d.w_reg_addr      = cfg_if.rca_inputs.w_reg_addr;
          id_d                  = cfg_if.issue_id;
          if (int'(cfg_if.rca_inputs.rca_sel) < NUM_RCAS) begin
            busy_d[cfg_if.rca_inputs.rca_sel] = 1'b1;
          end
          state_d = RCA_CFG_DRAIN;
        end
      end
      RCA_CFG_DRAIN: begin
        if (flush) begin
          busy_d  = '0;
          state_d = RCA_CFG_IDLE;
        end else if (drained) begin
          state_d = RCA_CFG_WRITE;
        end
      end
      RCA_CFG_WRITE: begin
        if (sel_ok && src_ok) begin
          tables_d[req_q.rca_sel].src[req_q.w_port_sel[RD_IDX_W-1:0]] = req_q.w_reg_addr;
        end else if (sel_ok && dest_ok) begin
          tables_d[req_q.rca_sel].dest[req_q.w_port_sel[WR_IDX_W-1:0]] = req_q.w_reg_addr;
        end
        busy_d  = '0;
        state_d = RCA_CFG_RESPOND;
      end
      RCA_CFG_RESPOND: begin
        if (cfg_if.wb_ack) state_d = RCA_CFG_IDLE;
      end
      default: state_d = RCA_CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RCA_CFG_IDLE;
      req_q    <= '0;
      id_q     <= '0;
      busy_q   <= '0;
      tables_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      id_q     <= id_d;
      busy_q   <= busy_d;
      tables_q <= tables_d;
    end
  end

  always_comb begin
    lookup_config = '0;
    if (int'(lookup_sel) < NUM_RCAS) lookup_config = tables_q[lookup_sel];
  end

`ifdef RCA_CONFIG_READBACK_EN
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic [REG_ADDR_W-1:0] prev_entry;

  always_comb begin
    prev_entry = '0;
    if (sel_ok && src_ok) begin
      prev_entry = tables_q[req_q.rca_sel].src[req_q.w_port_sel[RD_IDX_W-1:0]];
    end else if (sel_ok && dest_ok) begin
      prev_entry = tables_q[req_q.rca_sel].dest[req_q.w_port_sel[WR_IDX_W-1:0]];
    end
    wb_data_d = wb_data_q;
    if (state_q == RCA_CFG_WRITE) wb_data_d = XLEN'(prev_entry);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_data_q <= '0;
    else      wb_data_q <= wb_data_d;
  end

  assign cfg_if.wb_data = wb_data_q;
`else
  assign cfg_if.wb_data = '0;
`endif

  assign cfg_if.issue_ready = (state_q == RCA_CFG_IDLE);
  assign cfg_if.wb_done     = (state_q == RCA_CFG_RESPOND);
  assign cfg_if.wb_id       = id_q;
  assign rca_busy           = busy_q;
  assign state_dbg          = state_q;

endmodule
